// File: rtl/ula_pkg.sv
// Shared ULA definitions: divider FSM states, ALU category and arithmetic op codes.
package ula_pkg;

  localparam int ULA_WIDTH = 8;

  localparam logic [1:0] CAT_ARITH = 2'b00;
  localparam logic [1:0] CAT_LOGIC = 2'b01;
  localparam logic [1:0] CAT_SHIFT = 2'b10;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SNE  = 3'b110;
  localparam logic [2:0] OP_SEQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/ula_div_seq_if.sv
// Start/busy/done handshake bundle of the sequential divider.
// ULA_DIV_SIGNED_EN adds the signed_op request bit.
interface ula_div_seq_if #(
  parameter int WIDTH = ula_pkg::ULA_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef ULA_DIV_SIGNED_EN
  logic             signed_op;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef ULA_DIV_SIGNED_EN
  modport master (output start, dividend, divisor, signed_op,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor, signed_op,
                  output busy, done, quotient, remainder, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
`endif

endinterface

// File: rtl/ula_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module ula_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] pr,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] pr_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // When the subtract is taken the difference is below divisor, so WIDTH bits suffice.
  always_comb begin
    shifted = {pr, dvd_bit};
    diff    = shifted[WIDTH-1:0] - divisor;
    q_bit   = (shifted >= {1'b0, divisor});
    pr_next = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/ula_div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, for the ULA in_div path.
// Define ULA_DIV_SIGNED_EN to add two's-complement division selected by signed_op.
module ula_div_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  ula_div_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] pr_q, dvd_q, dsr_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q, neg_rem_q;
  logic [WIDTH-1:0] pr_nxt;
  logic             q_bit;
  logic             accept, dz_in, last_iter;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(v);
    return neg ? unsigned'(-sv) : v;
  endfunction

  assign accept    = bus.start && (state != CALC);
  assign dz_in     = (bus.divisor == '0);
  assign last_iter = (state == CALC) && (cnt_q == '0);

`ifdef ULA_DIV_SIGNED_EN
  assign sign_a = bus.signed_op & bus.dividend[WIDTH-1];
  assign sign_b = bus.signed_op & bus.divisor[WIDTH-1];
`else
  assign sign_a = 1'b0;
  assign sign_b = 1'b0;
`endif
  // A most-negative operand maps to 2**(WIDTH-1), which still fits unsigned.
  assign mag_a = cond_neg(bus.dividend, sign_a);
  assign mag_b = cond_neg(bus.divisor, sign_b);

  ula_div_step #(.WIDTH(WIDTH)) u_step (
    .pr      (pr_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dsr_q),
    .pr_next (pr_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE, DONE: begin
        bus.done  = (state == DONE);
        state_nxt = bus.start ? (dz_in ? DONE : CALC) : IDLE;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (cnt_q == '0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration registers: the dividend register shifts out operand bits and shifts in quotient bits.
  always_ff @(posedge clk) begin
    if (accept) begin
      pr_q      <= '0;
      dvd_q     <= mag_a;
      dsr_q     <= mag_b;
      cnt_q     <= CW'(WIDTH - 1);
      neg_quo_q <= sign_a ^ sign_b;
      neg_rem_q <= sign_a;
    end else if (state == CALC) begin
      pr_q  <= pr_nxt;
      dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Result registers change only when entering DONE, so they hold through IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else if (accept && dz_in) begin
      bus.quotient    <= '1;
      bus.remainder   <= bus.dividend;
      bus.div_by_zero <= 1'b1;
    end else if (last_iter) begin
      bus.quotient    <= cond_neg({dvd_q[WIDTH-2:0], q_bit}, neg_quo_q);
      bus.remainder   <= cond_neg(pr_nxt, neg_rem_q);
      bus.div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ula_div_seq.sv
// Scoreboard bench for ula_div_seq: expected results queued at start, compared on each done pulse.
module tb_ula_div_seq;
  import ula_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_div_seq_if #(.WIDTH(W)) bus ();

  ula_div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
    int           nbusy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt <= 0;
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient", bus.quotient, mon_e.q);
        check("remainder", bus.remainder, mon_e.r);
        check("div_by_zero", bus.div_by_zero, mon_e.dz);
        check("done_latency", cyc, mon_e.cyc);
        check("busy_cycles", busy_cnt, mon_e.nbusy);
      end
      busy_cnt <= 0;
    end else if (bus.busy) begin
      busy_cnt <= busy_cnt + 1;
    end
  end

  // Called just after a rising edge; start is sampled at the following edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sg, input bit expect_it);
    exp_t e;
    int   sa, sb, qi, ri;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef ULA_DIV_SIGNED_EN
    bus.signed_op = sg;
`endif
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.cyc = cyc + 1; e.nbusy = 0;
    end else begin
      if (sg) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = int'(a);
        sb = int'(b);
      end
      qi = sa / sb;
      ri = sa % sb;
      e.q = qi[W-1:0]; e.r = ri[W-1:0]; e.dz = 1'b0;
      e.cyc = cyc + W + 1; e.nbusy = W;
    end
    if (expect_it) exp_q.push_back(e);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.done) check("done_timeout", 0, 1);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_q"}, bus.quotient, 0);
    check({tag, "_r"}, bus.remainder, 0);
    check({tag, "_dz"}, bus.div_by_zero, 0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef ULA_DIV_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;
    next_cycle();

    start_op(8'd100, 8'd7, 1'b0, 1'b1);
    wait_done();
    next_cycle();
    repeat (3) next_cycle();
    check("hold_q", bus.quotient, 8'h0E);
    check("hold_r", bus.remainder, 8'd2);

    start_op(8'd255, 8'd1, 1'b0, 1'b1);
    wait_done();
    start_op(8'd3, 8'd200, 1'b0, 1'b1);
    wait_done();
    next_cycle();

    start_op(8'd5, 8'd0, 1'b0, 1'b1);
    wait_done();
    next_cycle();

    start_op(8'd100, 8'd7, 1'b0, 1'b1);
    repeat (2) next_cycle();
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    next_cycle();
    bus.start = 1'b0;
    wait_done();
    next_cycle();

    start_op(8'd100, 8'd7, 1'b0, 1'b0);
    repeat (3) next_cycle();
    rst_n = 1'b0;
    next_cycle();
    check_cleared("midreset");
    rst_n = 1'b1;
    next_cycle();
    start_op(8'd9, 8'd3, 1'b0, 1'b1);
    wait_done();
    next_cycle();

    for (int i = 0; i < 8; i++) begin
      start_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0, 1'b1);
      wait_done();
      next_cycle();
    end

`ifdef ULA_DIV_SIGNED_EN
    start_op(8'h9C, 8'd7, 1'b1, 1'b1);
    wait_done();
    next_cycle();
    start_op(8'h80, 8'hFF, 1'b1, 1'b1);
    wait_done();
    next_cycle();
    start_op(8'hF6, 8'd0, 1'b1, 1'b1);
    wait_done();
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      start_op(W'($urandom_range(0, 255)), W'($urandom_range(1, 255)), 1'b1, 1'b1);
      wait_done();
      next_cycle();
    end
`endif

    repeat (3) next_cycle();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_div_seq.md
Name: ula_div_seq

Overview:
- Multi-cycle restoring divider for the ULA arithmetic path; its quotient drives the ULA output mux `in_div` input (category 00, op 3'b011).
- Computes one quotient bit per clock, so no wide combinational divider sits in the ALU path.
- Uses a start/busy/done handshake. The result is held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (ULA datapath is 8).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low, sampled on rising clk
- start  in  1  request; sampled only in IDLE or DONE
- dividend  in  WIDTH  numerator, captured when start is accepted
- divisor  in  WIDTH  denominator, captured when start is accepted
- busy  out  1  high while iterating
- done  out  1  single-cycle pulse; result valid
- quotient  out  WIDTH  to ULA mux in_div
- remainder  out  WIDTH  remainder of last division
- div_by_zero  out  1  last accepted operation had divisor == 0

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
  - Reset overrides everything, including mid-operation; the in-flight result is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and divisor!=0 -> capture operands, clear the partial remainder, iteration count=WIDTH-1, go to CALC.
  - start=1 and divisor==0 -> go to DONE directly.
- CALC:
  - Each cycle: shift {partial remainder, dividend MSB} left one bit.
  - If the shifted partial remainder >= divisor: subtract divisor and set the quotient bit to 1; else quotient bit is 0.
  - After WIDTH iterations, go to DONE.
  - start is ignored in CALC; no queuing.
- DONE:
  - done=1 for exactly this cycle; quotient/remainder/div_by_zero are updated in this cycle.
  - start=1 in DONE is accepted as from IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start sampled at edge T.
  - busy=1 for cycles T+1..T+WIDTH.
  - done=1 at cycle T+WIDTH+1 (9 cycles for WIDTH=8).
  - Divide by zero: done at T+1, busy never asserts.
- Divide by zero: quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- Outputs hold their last result through IDLE. They change only in a DONE cycle or on reset.
- Arithmetic:
  - Unsigned.
  - Partial remainder is WIDTH+1 bits internally so the compare cannot overflow.
  - Identity: dividend = quotient*divisor + remainder, with remainder < divisor.
- Operand inputs may change after acceptance without affecting the operation in flight.

Optional Feature:
- Macro: ULA_DIV_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), captured with start.
  - signed_op=1 selects two's-complement division. Operands are converted to magnitudes at accept; the same CALC loop runs; signs are applied in DONE.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Overflow case (most-negative / -1): quotient=most-negative (0x80), remainder=0, div_by_zero=0.
  - Divide by zero with signed_op=1: same outputs as the unsigned case.
  - Latency is unchanged.
- Undefined: no signed_op port; unsigned only.

Decomposition:
- Shared package ula_pkg holds:
  - the state enum (IDLE/CALC/DONE);
  - ULA category constants (ARITH=2'b00, LOGIC=2'b01, SHIFT=2'b10);
  - arithmetic op codes (ADD..SEQ, DIV=3'b011);
  - default WIDTH=8.
- One natural sub-module: ula_div_step, a combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.

Test Plan:
- Reset, then 100/7: done at T+9, quotient=14 (0x0E), remainder=2, div_by_zero=0, busy high for exactly 8 cycles.
- 255/1 -> quotient=0xFF, remainder=0. Then 3/200 -> quotient=0, remainder=3. Both started back-to-back on the DONE cycle.
- 5/0 -> done at T+1, quotient=0xFF, remainder=0x05, div_by_zero=1, busy never high.
- start=1 with 50/5 at cycle T+3 of a running 100/7 -> ignored. Result is 14 r 2, one done pulse only.
- rst_n=0 at cycle T+4 of 100/7 -> next cycle all outputs 0, state IDLE. A new 9/3 afterwards gives 3 r 0.
- With ULA_DIV_SIGNED_EN and signed_op=1:
  - -100/7 -> quotient=0xF2, remainder=0xFE.
  - -128/-1 -> quotient=0x80, remainder=0.
